// File: rtl/gpi_debounce_pkg.sv
// Shared defaults and helpers for the gpi_debounce input front end.
// The optional per-channel glitch counter is enabled by defining GPI_DEBOUNCE_GLITCH_CNT_EN.
package gpi_debounce_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 50000;
    localparam int unsigned SYNC_STAGES_DEF     = 2;
    localparam int unsigned GLITCH_CNT_W        = 8;

    typedef logic [GLITCH_CNT_W-1:0] glitch_cnt_t;

    // Clear is applied first, so a clear coinciding with an abort yields 1; saturates at all-ones.
    function automatic glitch_cnt_t glitch_cnt_next(glitch_cnt_t cur, logic clr, logic inc);
        glitch_cnt_t base;
        base = clr ? '0 : cur;
        if (inc && (base != '1)) begin
            base = base + 1'b1;
        end
        return base;
    endfunction

endpackage

// File: rtl/gpi_debounce_ch.sv
// Single channel: synchroniser, debounce counter, accepted level and registered edge pulses.
// With GPI_DEBOUNCE_GLITCH_CNT_EN defined, also counts aborted debounce attempts.
module gpi_debounce_ch
    import gpi_debounce_pkg::*;
#(
    parameter int unsigned SyncStages     = SYNC_STAGES_DEF,
    parameter int unsigned DebounceCycles = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CntWidth       = 16,
    parameter logic        ResetLevel     = 1'b0
) (
    input  logic                    clk_sys_i,
    input  logic                    rst_sys_ni,
    input  logic                    raw_i,
`ifdef GPI_DEBOUNCE_GLITCH_CNT_EN
    input  logic                    glitch_clr_i,
    output logic [GLITCH_CNT_W-1:0] glitch_cnt_o,
`endif
    output logic                    level_o,
    output logic                    rise_o,
    output logic                    fall_o
);

    localparam logic [CntWidth-1:0] CntLast = CntWidth'(DebounceCycles - 1);

    logic [SyncStages-1:0] sync_q, sync_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic                  level_q, level_d;
    logic                  rise_q, rise_d;
    logic                  fall_q, fall_d;
    logic                  sync_s;

    assign sync_s = sync_q[SyncStages-1];

    always_comb begin
        sync_d  = {sync_q[SyncStages-2:0], raw_i};
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync_s == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntLast) begin
            cnt_d   = '0;
            level_d = sync_s;
            rise_d  = sync_s;
            fall_d  = ~sync_s;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            sync_q  <= {SyncStages{ResetLevel}};
            cnt_q   <= '0;
            level_q <= ResetLevel;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

`ifdef GPI_DEBOUNCE_GLITCH_CNT_EN
    glitch_cnt_t glitch_q, glitch_d;
    logic        glitch_inc;

    // An attempt in progress that sees the input fall back to the accepted level.
    assign glitch_inc = (sync_s == level_q) && (cnt_q != '0);

    always_comb begin
        glitch_d = glitch_cnt_next(glitch_q, glitch_clr_i, glitch_inc);
    end

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            glitch_q <= '0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign glitch_cnt_o = glitch_q;
`endif

endmodule

// File: rtl/gpi_debounce.sv
// Multi-channel debounced GPI front end with sticky event flags and an aggregated interrupt.
// Optional glitch counters are enabled by defining GPI_DEBOUNCE_GLITCH_CNT_EN.
module gpi_debounce
    import gpi_debounce_pkg::*;
#(
    parameter int unsigned      NumCh          = 8,
    parameter int unsigned      SyncStages     = SYNC_STAGES_DEF,
    parameter int unsigned      DebounceCycles = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned      CntWidth       = 16,
    parameter logic [NumCh-1:0] ResetLevel     = '0
) (
    input  logic                          clk_sys_i,
    input  logic                          rst_sys_ni,
    input  logic [NumCh-1:0]              raw_i,
    output logic [NumCh-1:0]              level_o,
    output logic [NumCh-1:0]              rise_o,
    output logic [NumCh-1:0]              fall_o,
    input  logic [NumCh-1:0]              rise_en_i,
    input  logic [NumCh-1:0]              fall_en_i,
    output logic [NumCh-1:0]              pending_o,
    input  logic [NumCh-1:0]              pending_clr_i,
`ifdef GPI_DEBOUNCE_GLITCH_CNT_EN
    output logic [NumCh*GLITCH_CNT_W-1:0] glitch_cnt_o,
`endif
    output logic                          irq_o
);

    logic [NumCh-1:0] pending_q, pending_d;
    logic [NumCh-1:0] pending_set;

    for (genvar g = 0; g < NumCh; g++) begin : g_ch
        gpi_debounce_ch #(
            .SyncStages    (SyncStages),
            .DebounceCycles(DebounceCycles),
            .CntWidth      (CntWidth),
            .ResetLevel    (ResetLevel[g])
        ) u_ch (
            .clk_sys_i   (clk_sys_i),
            .rst_sys_ni  (rst_sys_ni),
            .raw_i       (raw_i[g]),
`ifdef GPI_DEBOUNCE_GLITCH_CNT_EN
            .glitch_clr_i(pending_clr_i[g]),
            .glitch_cnt_o(glitch_cnt_o[g*GLITCH_CNT_W +: GLITCH_CNT_W]),
`endif
            .level_o     (level_o[g]),
            .rise_o      (rise_o[g]),
            .fall_o      (fall_o[g])
        );
    end

    // Set is OR-ed after the clear so a coincident event is never lost.
    always_comb begin
        pending_set = (rise_o & rise_en_i) | (fall_o & fall_en_i);
        pending_d   = (pending_q & ~pending_clr_i) | pending_set;
    end

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;
    assign irq_o     = |pending_q;

endmodule
